// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared frame-buffer constants, writer state encoding and the
//                pixel-to-byte-address helper used by the pixel writer.
//                Frame layout: one 32-bit pixel per 8-byte slot, 640x480.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int          H_RES_DEF    = 640;
  localparam int          V_RES_DEF    = 480;
  localparam int          PIXEL_STRIDE = 8;
  localparam logic [25:0] FRAME_BYTES  = 26'h258000;
  localparam logic [25:0] LAST_OFFSET  = FRAME_BYTES - 26'(PIXEL_STRIDE);

  localparam int          ADDR_W = 26;
  localparam int          DATA_W = 32;
  localparam int          FIFO_W = ADDR_W + DATA_W;

  // Writer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t S_RUN   = 2'd0;
  localparam state_t S_DRAIN = 2'd1;
  localparam state_t S_CLEAR = 2'd2;

  // base + ((y*640 + x) << 3), wrapping modulo 2^26.
  // y*640 is built from two shifts: (y<<9) + (y<<7).
  function automatic logic [25:0] pix_addr(input logic [25:0] base,
                                           input logic [9:0]  x,
                                           input logic [8:0]  y);
    logic [25:0] lin;
    lin = ({17'd0, y} << 9) + ({17'd0, y} << 7) + {16'd0, x};
    return base + (lin << 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fb_wr_fifo
//  Description : Synchronous FIFO holding {address, colour} pixel writes.
//                Simultaneous push and pop are allowed; a push while full
//                and a pop while empty are ignored.
//  Ports       : clk, reset (sync, active-high), push/din, pop/dout,
//                full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 58
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pixel_writer
//  Description : Accepts (x, y, colour) pixel writes, converts them to SDRAM
//                frame-buffer byte addresses and issues Avalon-MM writes.
//                Also performs a hardware full-frame clear fill.
//  Ports       : clk, reset (sync, active-high), base
//                pix_valid/pix_ready/pix_x/pix_y/pix_color  - pixel input
//                clear_req/clear_color/clear_done            - clear fill
//                busy                                        - work pending
//                master_address/write/writedata/waitrequest  - Avalon master
//  Options     : FB_WRITER_STATS_EN adds wr_count (completed writes) and
//                drop_count (out-of-range pixels, saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] base,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [31:0] pix_color,
  input  logic        clear_req,
  input  logic [31:0] clear_color,
  output logic        clear_done,
  output logic        busy,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
`ifdef FB_WRITER_STATS_EN
  ,
  output logic [31:0] wr_count,
  output logic [15:0] drop_count
`endif
);

  // The fill covers H_RES*V_RES slots; at the default geometry this is
  // exactly the standard frame ending at LAST_OFFSET.
  localparam logic [25:0] FILL_LAST =
    (H_RES == H_RES_DEF && V_RES == V_RES_DEF) ? LAST_OFFSET
                                               : 26'((H_RES * V_RES - 1) * PIXEL_STRIDE);
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  // Registers
  state_t      state_q,      state_d;
  logic        rdy_en_q;
  logic        mw_q,         mw_d;
  logic [25:0] addr_q,       addr_d;
  logic [31:0] data_q,       data_d;
  logic        done_q,       done_d;
  logic [31:0] clr_color_q,  clr_color_d;
  logic [25:0] clr_base_q,   clr_base_d;
  logic [25:0] offset_q,     offset_d;
  logic        fill_last_q,  fill_last_d;

  // FIFO interface
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_din;
  logic [FIFO_W-1:0] w_dout;

  logic w_accept;
  logic w_in_range;
  logic w_fire;
  logic w_slot_free;

  // rdy_en_q keeps pix_ready low during reset and for the first cycle out.
  assign pix_ready   = rdy_en_q && !w_full && (state_q == S_RUN);
  assign w_accept    = pix_valid && pix_ready;
  assign w_in_range  = ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
  assign w_push      = w_accept && w_in_range;
  assign w_din       = {pix_addr(base, pix_x, pix_y), pix_color};

  assign w_fire      = mw_q && !master_waitrequest;
  assign w_slot_free = !mw_q || w_fire;

  assign master_write     = mw_q;
  assign master_address   = addr_q;
  assign master_writedata = data_q;
  assign clear_done       = done_q;
  assign busy             = (state_q != S_RUN) || !w_empty || mw_q;

  fb_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    state_d     = state_q;
    mw_d        = mw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    clr_color_d = clr_color_q;
    clr_base_d  = clr_base_q;
    offset_d    = offset_q;
    fill_last_d = fill_last_q;
    w_pop       = 1'b0;

    // Pixel streaming: output stage refills from the FIFO head whenever it
    // is empty or its current write completes this edge.
    if (state_q != S_CLEAR && w_slot_free) begin
      if (!w_empty) begin
        w_pop  = 1'b1;
        mw_d   = 1'b1;
        addr_d = w_dout[FIFO_W-1:DATA_W];
        data_d = w_dout[DATA_W-1:0];
      end else begin
        mw_d   = 1'b0;
      end
    end

    case (state_q)
      S_RUN: begin
        if (clear_req) begin
          state_d     = S_DRAIN;
          clr_color_d = clear_color;
          clr_base_d  = base;
          offset_d    = '0;
          fill_last_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (w_empty && !mw_q) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (w_slot_free) begin
          if (!fill_last_q) begin
            mw_d   = 1'b1;
            addr_d = clr_base_q + offset_q;
            data_d = clr_color_q;
            if (offset_q == FILL_LAST) fill_last_d = 1'b1;
            else                       offset_d    = offset_q + 26'(PIXEL_STRIDE);
          end else begin
            // Final fill write has just completed (or was never stalled).
            mw_d        = 1'b0;
            fill_last_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_RUN;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      rdy_en_q    <= 1'b0;
      mw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      clr_color_q <= '0;
      clr_base_q  <= '0;
      offset_q    <= '0;
      fill_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      mw_q        <= mw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      clr_color_q <= clr_color_d;
      clr_base_q  <= clr_base_d;
      offset_q    <= offset_d;
      fill_last_q <= fill_last_d;
    end
  end

`ifdef FB_WRITER_STATS_EN
  logic [31:0] wr_count_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      if (w_fire) wr_count_q <= wr_count_q + 32'd1;
      if (w_accept && !w_in_range && drop_count_q != 16'hFFFF)
        drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_pixel_writer
//  Description : Scoreboard bench for fb_pixel_writer. A reduced 64x8 frame
//                keeps the clear fill short; pixel addressing still uses the
//                fixed 640-pixel line pitch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_pixel_writer;

  localparam int H = 64;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] base = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic [31:0] pix_color = '0;
  logic        clear_req = 1'b0;
  logic [31:0] clear_color = '0;
  logic        clear_done;
  logic        busy;
  logic [25:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest = 1'b0;
`ifdef FB_WRITER_STATS_EN
  logic [31:0] wr_count;
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  fb_pixel_writer #(
    .DEPTH (16),
    .H_RES (H),
    .V_RES (V)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .base               (base),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .pix_x              (pix_x),
    .pix_y              (pix_y),
    .pix_color          (pix_color),
    .clear_req          (clear_req),
    .clear_color        (clear_color),
    .clear_done         (clear_done),
    .busy               (busy),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest)
`ifdef FB_WRITER_STATS_EN
    ,
    .wr_count           (wr_count),
    .drop_count         (drop_count)
`endif
  );

  typedef struct packed {
    logic [25:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  exp_pushed = 0;
  int  writes_seen = 0;
  bit  rand_wait = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] model_addr(input logic [25:0] b, input int x, input int y);
    return b + 26'((y * 640 + x) * 8);
  endfunction

  task automatic push_exp(input logic [25:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    exp_pushed++;
  endtask

  task automatic send_pix(input int x, input int y, input logic [31:0] c);
    int n;
    pix_x     = 10'(x);
    pix_y     = 9'(y);
    pix_color = c;
    pix_valid = 1'b1;
    n = 0;
    while (!pix_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_val("ready_timeout", n, 0);
    @(posedge clk);
    if (x < H && y < V) push_exp(model_addr(base, x, y), c);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check_val("idle_timeout", n, 0);
  endtask

  task automatic run_clear(input string tag);
    int n;
    int ready_bad;
    int w0;
    w0 = writes_seen;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    ready_bad = 0;
    while (!clear_done && n < 20000) begin
      if (pix_ready) ready_bad++;
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done_seen"}, clear_done, 1);
    check_val({tag, "_ready_low"}, ready_bad, 0);
    check_val({tag, "_all_written"}, exp_q.size(), 0);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, clear_done, 0);
    check_val({tag, "_ready_back"}, pix_ready, 1);
    check_val({tag, "_busy_clear"}, busy, 0);
    check_val({tag, "_nwrites_min"}, (writes_seen - w0) >= H * V, 1);
  endtask

  // Random waitrequest, updated just after each rising edge when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_wait) master_waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // Bus monitor: sampled late in the cycle, after all input drives.
  initial begin
    logic        prev_stall;
    logic [25:0] prev_a;
    logic [31:0] prev_d;
    wr_t         e;
    prev_stall = 1'b0;
    prev_a = '0;
    prev_d = '0;
    forever begin
      @(posedge clk);
      #8;
      if (!reset) begin
        if (prev_stall) begin
          check_val("hold_addr", master_address, prev_a);
          check_val("hold_data", master_writedata, prev_d);
          check_val("hold_write", master_write, 1);
        end
        if (master_write && !master_waitrequest) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            check_val("unexpected_write", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_val("wr_addr", master_address, e.a);
            check_val("wr_data", master_writedata, e.d);
          end
        end
        prev_stall = master_write && master_waitrequest;
        prev_a     = master_address;
        prev_d     = master_writedata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int w0;

    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ready", pix_ready, 0);
    check_val("rst_done", clear_done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_write", master_write, 0);
    check_val("rst_addr", master_address, 0);
    check_val("rst_data", master_writedata, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", pix_ready, 1);
`ifdef FB_WRITER_STATS_EN
    check_val("rst_wr_count", wr_count, 0);
    check_val("rst_drop_count", drop_count, 0);
`endif

    // ---------------- single pixel, no stall ----------------
    base = 26'h100000;
    w0 = writes_seen;
    send_pix(1, 2, 32'h00FF00FF);
    check_val("lat_not_yet", master_write, 0);
    @(negedge clk);
    check_val("lat_write", master_write, 1);
    check_val("lat_addr", master_address, 26'h102808);
    check_val("lat_data", master_writedata, 32'h00FF00FF);
    @(negedge clk);
    check_val("one_cycle_write", master_write, 0);
    check_val("single_count", writes_seen - w0, 1);

    // ---------------- single pixel, 5 stall cycles ----------------
    master_waitrequest = 1'b1;
    w0 = writes_seen;
    send_pix(1, 2, 32'h00FF00FF);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check_val("stall_write", master_write, 1);
      check_val("stall_addr", master_address, 26'h102808);
      if (i == 5) master_waitrequest = 1'b0;
      @(negedge clk);
    end
    check_val("stall_released", master_write, 0);
    check_val("stall_count", writes_seen - w0, 1);

    // ---------------- FIFO full: 1 in output stage + 16 queued ----------------
    master_waitrequest = 1'b1;
    base = 26'h0012340;
    send_pix(0, 1, 32'h00000AAA);
    for (int i = 0; i < 16; i++) send_pix(i + 2, 3, 32'h00001000 + i);
    check_val("full_ready", pix_ready, 0);
    check_val("full_busy", busy, 1);
    repeat (3) @(negedge clk);
    check_val("full_ready_hold", pix_ready, 0);
    master_waitrequest = 1'b0;
    @(negedge clk);
    check_val("ready_after_pop", pix_ready, 1);
    wait_idle();
    check_val("burst_drained", exp_q.size(), 0);

    // ---------------- out-of-range pixels and far corner ----------------
    w0 = writes_seen;
    send_pix(640, 0, 32'h00DEAD01);
    send_pix(0, 480, 32'h00DEAD02);
    for (int i = 0; i < 4; i++) begin
      check_val("oor_busy", busy, 0);
      check_val("oor_write", master_write, 0);
      @(negedge clk);
    end
    check_val("oor_count", writes_seen - w0, 0);
`ifdef FB_WRITER_STATS_EN
    check_val("drop_count", drop_count, 2);
`endif
    send_pix(H - 1, V - 1, 32'h00123456);
    wait_idle();
    check_val("corner_drained", exp_q.size(), 0);

    // ---------------- clear fill, random waitrequest ----------------
    @(negedge clk);
    base = 26'h0;
    clear_color = 32'hFFFFFFFF;
    for (int o = 0; o < H * V; o++) push_exp(26'(o * 8), 32'hFFFFFFFF);
    rand_wait = 1'b1;
    run_clear("clr");
    rand_wait = 1'b0;
    master_waitrequest = 1'b0;
`ifdef FB_WRITER_STATS_EN
    check_val("wr_count", wr_count, exp_pushed);
`endif

    // ---------------- queued pixels ahead of a clear ----------------
    @(negedge clk);
    master_waitrequest = 1'b1;
    base = 26'h200000;
    send_pix(5, 1, 32'h00000001);
    send_pix(6, 1, 32'h00000002);
    send_pix(7, 1, 32'h00000003);
    base = 26'h300000;
    clear_color = 32'h00ABCDEF;
    for (int o = 0; o < H * V; o++) push_exp(26'h300000 + 26'(o * 8), 32'h00ABCDEF);
    rand_wait = 1'b1;
    fork
      run_clear("clr2");
      begin
        // A second request while draining must be ignored.
        @(negedge clk);
        @(negedge clk);
        clear_color = 32'h12345678;
        base = 26'h3FF000;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
      end
    join
    rand_wait = 1'b0;
    master_waitrequest = 1'b0;

    // ---------------- reset during activity ----------------
    @(negedge clk);
    master_waitrequest = 1'b1;
    base = 26'h050000;
    for (int i = 0; i < 6; i++) send_pix(i, 4, 32'h00770000 + i);
    check_val("pre_rst_write", master_write, 1);
    check_val("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_write", master_write, 0);
    check_val("mid_rst_busy", busy, 0);
    exp_q.delete();
    exp_pushed = 0;
    reset = 1'b0;
    master_waitrequest = 1'b0;
    w0 = writes_seen;
    repeat (20) @(negedge clk);
    check_val("post_rst_writes", writes_seen - w0, 0);
    check_val("post_rst_ready", pix_ready, 1);
    check_val("post_rst_busy", busy, 0);
`ifdef FB_WRITER_STATS_EN
    check_val("post_rst_wr_count", wr_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
